// File: rtl/twiddle_pkg.sv
// Shared definitions for the twiddle-factor generator: quadrant type,
// the elaboration-time quarter-wave cosine generator and the
// saturating negation used when folding the quarter wave into a full turn.
package twiddle_pkg;

  // Quadrant of the twiddle index: addr[LOG_N-1:LOG_N-2].
  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } tw_quad_e;

  // Fixed-point format used while building the table: 48 fractional bits.
  // The table is built with integer arithmetic only, so it elaborates the
  // same way in every tool without relying on real-valued constant math.
  localparam int TW_FRAC = 48;

  // pi * 2^48, truncated.
  localparam logic signed [127:0] TW_PI_FX = 128'sh3243F6A8885A3;

  // Taylor terms for cos(x) on [0, pi/2]; x^26/26! is far below 2^-48.
  localparam int TW_TAYLOR_TERMS = 12;

  // Largest and smallest codes of a signed tw_width-bit value.
  function automatic int tw_max(input int tw_width);
    return (1 << (tw_width - 1)) - 1;
  endfunction

  function automatic int tw_min(input int tw_width);
    return -(1 << (tw_width - 1));
  endfunction

  // C[i] = round(cos(2*pi*i/N) * 2^(tw_width-1)), clipped to MAX.
  // Angle is pi*i/2^(log_n-1); cos is evaluated with a Taylor series in
  // 48-bit fraction fixed point, then rounded half-up to tw_width bits.
  function automatic int tw_cos_entry(input int i, input int log_n,
                                      input int tw_width);
    logic signed [127:0] x;
    logic signed [127:0] x2;
    logic signed [127:0] term;
    logic signed [127:0] sum;
    logic signed [127:0] scaled;
    logic signed [127:0] max_fx;
    x    = (TW_PI_FX * 128'(i)) >>> (log_n - 1);
    x2   = (x * x) >>> TW_FRAC;
    term = 128'sd1 <<< TW_FRAC;
    sum  = term;
    for (int n = 1; n <= TW_TAYLOR_TERMS; n++) begin
      term = (term * x2) >>> TW_FRAC;
      term = term / 128'((2 * n - 1) * (2 * n));
      if ((n % 2) == 1) sum = sum - term;
      else              sum = sum + term;
    end
    scaled = ((sum <<< (tw_width - 1)) + (128'sd1 <<< (TW_FRAC - 1))) >>> TW_FRAC;
    max_fx = 128'(tw_max(tw_width));
    if (scaled > max_fx) scaled = max_fx;
    if (scaled < 0)      scaled = '0;
    return int'(scaled[31:0]);
  endfunction

  // Negation for folded table values. The table stores +1.0 as MAX, so
  // negating MAX must give the exact -1.0 code (MIN); negating MIN (which
  // only appears after an earlier fold to -1.0) saturates back to MAX.
  function automatic int sat_neg(input int value, input int tw_width);
    if (value == tw_max(tw_width))      return tw_min(tw_width);
    else if (value == tw_min(tw_width)) return tw_max(tw_width);
    else                                return -value;
  endfunction

endpackage

// File: rtl/twiddle_qrom.sv
// Quarter-wave cosine table with two independent combinational read ports.
// Entries 0..N/4 are constants computed at elaboration; the second port is
// used for the complementary angle (N/4 - r), which yields the sine.
module twiddle_qrom
  import twiddle_pkg::*;
#(
  parameter int LOG_N    = 7,
  parameter int TW_WIDTH = 16
) (
  input  logic [LOG_N-2:0]    i_ia,
  input  logic [LOG_N-2:0]    i_ib,
  output logic [TW_WIDTH-1:0] o_a,
  output logic [TW_WIDTH-1:0] o_b
);

  localparam int Q = 1 << (LOG_N - 2);

  logic [TW_WIDTH-1:0] w_table [0:Q];

  // One constant per entry; index ranges are 0..Q-1 (port a) and 1..Q (port b).
  for (genvar gi = 0; gi <= Q; gi++) begin : g_entry
    localparam logic [TW_WIDTH-1:0] ENTRY = TW_WIDTH'(tw_cos_entry(gi, LOG_N, TW_WIDTH));
    assign w_table[gi] = ENTRY;
  end

  assign o_a = w_table[i_ia];
  assign o_b = w_table[i_ib];

endmodule

// File: rtl/twiddle_gen.sv
// Twiddle-factor generator W_N^k = exp(-j*2*pi*k/N) for SDF FFT stages.
// Three pipeline stages:
//   1. split addr into quadrant and in-quadrant offset, form table indices
//   2. two parallel quarter-wave table reads
//   3. quadrant fold, optional conjugate, zero override, output registers
// Handshake: a request is accepted on a rising clock edge where en=1 and
// in_valid=1; its result is presented with tw_valid=1 after the third
// enabled edge. en=0 freezes every stage. Outputs hold the last valid result
// while tw_valid=0.
module twiddle_gen
  import twiddle_pkg::*;
#(
  parameter int LOG_N     = 7,
  parameter int TW_WIDTH  = 16,
  parameter int ZERO_AT_0 = 1
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                en,
  input  logic                in_valid,
  input  logic [LOG_N-1:0]    addr,
  input  logic                inverse,
  output logic                tw_valid,
  output logic [TW_WIDTH-1:0] tw_re,
  output logic [TW_WIDTH-1:0] tw_im
);

  // Offset width within a quadrant, and index width (holds 0..Q inclusive).
  localparam int RW = LOG_N - 2;
  localparam int QW = LOG_N - 1;
  localparam int Q  = 1 << RW;

  // ---------------- stage 1 ----------------
  logic [RW-1:0]  w_r;
  logic [QW-1:0]  w_ia;
  logic [QW-1:0]  w_ib;
  logic           w_zero;

  tw_quad_e       r_q1;
  logic [QW-1:0]  r_ia1;
  logic [QW-1:0]  r_ib1;
  logic           r_zero1;
  logic           r_inv1;
  logic           r_v1;

  assign w_r    = addr[RW-1:0];
  assign w_ia   = {1'b0, w_r};
  assign w_ib   = QW'(Q) - {1'b0, w_r};
  assign w_zero = (addr == '0) && (ZERO_AT_0 != 0);

  // Stage 1: capture quadrant, both table indices and sideband bits.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_q1    <= Q0;
      r_ia1   <= '0;
      r_ib1   <= '0;
      r_zero1 <= 1'b0;
      r_inv1  <= 1'b0;
      r_v1    <= 1'b0;
    end else if (en) begin
      r_q1    <= tw_quad_e'(addr[LOG_N-1:LOG_N-2]);
      r_ia1   <= w_ia;
      r_ib1   <= w_ib;
      r_zero1 <= w_zero;
      r_inv1  <= inverse;
      r_v1    <= in_valid;
    end
  end

  // ---------------- stage 2 ----------------
  logic [TW_WIDTH-1:0] w_a;
  logic [TW_WIDTH-1:0] w_b;

  twiddle_qrom #(
    .LOG_N    (LOG_N),
    .TW_WIDTH (TW_WIDTH)
  ) u_qrom (
    .i_ia (r_ia1),
    .i_ib (r_ib1),
    .o_a  (w_a),
    .o_b  (w_b)
  );

  logic [TW_WIDTH-1:0] r_a2;
  logic [TW_WIDTH-1:0] r_b2;
  tw_quad_e            r_q2;
  logic                r_zero2;
  logic                r_inv2;
  logic                r_v2;

  // Stage 2: register A = cos(r), B = cos(Q - r) = sin(r) and sideband.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_a2    <= '0;
      r_b2    <= '0;
      r_q2    <= Q0;
      r_zero2 <= 1'b0;
      r_inv2  <= 1'b0;
      r_v2    <= 1'b0;
    end else if (en) begin
      r_a2    <= w_a;
      r_b2    <= w_b;
      r_q2    <= r_q1;
      r_zero2 <= r_zero1;
      r_inv2  <= r_inv1;
      r_v2    <= r_v1;
    end
  end

  // ---------------- stage 3 ----------------
  logic [TW_WIDTH-1:0] w_neg_a;
  logic [TW_WIDTH-1:0] w_neg_b;
  logic [TW_WIDTH-1:0] w_fold_re;
  logic [TW_WIDTH-1:0] w_fold_im;
  logic [TW_WIDTH-1:0] w_conj_im;
  logic [TW_WIDTH-1:0] w_out_re;
  logic [TW_WIDTH-1:0] w_out_im;

  assign w_neg_a = TW_WIDTH'(sat_neg(int'($signed(r_a2)), TW_WIDTH));
  assign w_neg_b = TW_WIDTH'(sat_neg(int'($signed(r_b2)), TW_WIDTH));

  // Fold the first-quadrant (cos, sin) pair into the addressed quadrant.
  always_comb begin
    w_fold_re = r_b2;
    w_fold_im = r_a2;
    case (r_q2)
      Q0: begin
        w_fold_re = r_a2;
        w_fold_im = w_neg_b;
      end
      Q1: begin
        w_fold_re = w_neg_b;
        w_fold_im = w_neg_a;
      end
      Q2: begin
        w_fold_re = w_neg_a;
        w_fold_im = r_b2;
      end
      default: begin
        w_fold_re = r_b2;
        w_fold_im = r_a2;
      end
    endcase
  end

  // Conjugate for IFFT requests; -MIN saturates to MAX here.
  assign w_conj_im = r_inv2 ? TW_WIDTH'(sat_neg(int'($signed(w_fold_im)), TW_WIDTH))
                            : w_fold_im;

  // k=0 bypass marker overrides the table result.
  assign w_out_re = r_zero2 ? '0 : w_fold_re;
  assign w_out_im = r_zero2 ? '0 : w_conj_im;

  logic                r_tw_valid;
  logic [TW_WIDTH-1:0] r_tw_re;
  logic [TW_WIDTH-1:0] r_tw_im;

  // Stage 3: valid follows stage 2 on every enabled edge; data loads only
  // for valid results so bubbles leave the last twiddle on the outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_tw_valid <= 1'b0;
      r_tw_re    <= '0;
      r_tw_im    <= '0;
    end else if (en) begin
      r_tw_valid <= r_v2;
      if (r_v2) begin
        r_tw_re <= w_out_re;
        r_tw_im <= w_out_im;
      end
    end
  end

  assign tw_valid = r_tw_valid;
  assign tw_re    = r_tw_re;
  assign tw_im    = r_tw_im;

endmodule

// File: tb/tb_twiddle_gen.sv
// Self-checking bench for twiddle_gen. Four instances cover LOG_N/TW_WIDTH/
// ZERO_AT_0 combinations; all see the same stimulus and one is selected for
// checking at a time. Expected values come from a real-valued cos/-sin model.
module tb_twiddle_gen;

  localparam int NDUT = 4;
  localparam real PI  = 3.14159265358979323846;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  logic       en;
  logic       in_valid;
  logic       inverse;
  logic [9:0] addr_bus;
  int         sel;

  // Per-instance parameters, indexed by sel.
  int p_log [NDUT] = '{7, 7, 3, 10};
  int p_w   [NDUT] = '{16, 16, 12, 18};
  bit p_z   [NDUT] = '{1'b1, 1'b0, 1'b1, 1'b1};

  logic        v0, v1, v2, v3;
  logic [15:0] re0, im0, re1, im1;
  logic [11:0] re2, im2;
  logic [17:0] re3, im3;

  twiddle_gen #(.LOG_N(7), .TW_WIDTH(16), .ZERO_AT_0(1)) dut0 (
    .clock(clock), .reset_n(reset_n), .en(en), .in_valid(in_valid),
    .addr(addr_bus[6:0]), .inverse(inverse),
    .tw_valid(v0), .tw_re(re0), .tw_im(im0));

  twiddle_gen #(.LOG_N(7), .TW_WIDTH(16), .ZERO_AT_0(0)) dut1 (
    .clock(clock), .reset_n(reset_n), .en(en), .in_valid(in_valid),
    .addr(addr_bus[6:0]), .inverse(inverse),
    .tw_valid(v1), .tw_re(re1), .tw_im(im1));

  twiddle_gen #(.LOG_N(3), .TW_WIDTH(12), .ZERO_AT_0(1)) dut2 (
    .clock(clock), .reset_n(reset_n), .en(en), .in_valid(in_valid),
    .addr(addr_bus[2:0]), .inverse(inverse),
    .tw_valid(v2), .tw_re(re2), .tw_im(im2));

  twiddle_gen #(.LOG_N(10), .TW_WIDTH(18), .ZERO_AT_0(1)) dut3 (
    .clock(clock), .reset_n(reset_n), .en(en), .in_valid(in_valid),
    .addr(addr_bus), .inverse(inverse),
    .tw_valid(v3), .tw_re(re3), .tw_im(im3));

  // Selected instance, outputs sign-extended to 32 bits.
  logic               obs_v;
  logic signed [31:0] obs_re;
  logic signed [31:0] obs_im;
  always_comb begin
    obs_v  = v0;
    obs_re = {{16{re0[15]}}, re0};
    obs_im = {{16{im0[15]}}, im0};
    case (sel)
      1: begin
        obs_v  = v1;
        obs_re = {{16{re1[15]}}, re1};
        obs_im = {{16{im1[15]}}, im1};
      end
      2: begin
        obs_v  = v2;
        obs_re = {{20{re2[11]}}, re2};
        obs_im = {{20{im2[11]}}, im2};
      end
      3: begin
        obs_v  = v3;
        obs_re = {{14{re3[17]}}, re3};
        obs_im = {{14{im3[17]}}, im3};
      end
      default: ;
    endcase
  end

  // ---------------- scoreboard state ----------------
  int                 checks = 0;
  int                 errors = 0;
  logic [31:0]        exp_re_q [$];
  logic [31:0]        exp_im_q [$];
  int                 tol_q [$];
  bit                 vhist [$];   // in_valid at the most recent enabled edges
  bit                 last_v;
  logic signed [31:0] last_re;
  logic signed [31:0] last_im;
  int                 last_tol;

  // ---------------- reference model ----------------
  function automatic int sat_round(input real x, input int w);
    int r;
    int mx;
    int mn;
    mx = (1 << (w - 1)) - 1;
    mn = -(1 << (w - 1));
    if (x >= 0.0) r = $rtoi(x + 0.5);
    else          r = -$rtoi(-x + 0.5);
    if (r > mx) r = mx;
    if (r < mn) r = mn;
    return r;
  endfunction

  // W_N^k = cos(th) - j sin(th); conjugate flips the sign of the sine.
  function automatic void model(input int k, input int log_n, input int w,
                                input bit zat0, input bit inv,
                                output int re, output int im);
    real th;
    real sc;
    th = 2.0 * PI * real'(k) / real'(1 << log_n);
    sc = real'(1 << (w - 1));
    re = sat_round($cos(th) * sc, w);
    im = sat_round((inv ? $sin(th) : -$sin(th)) * sc, w);
    if (zat0 && k == 0) begin
      re = 0;
      im = 0;
    end
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] expv, input int tol);
    logic signed [31:0] d;
    checks++;
    d = obs - expv;
    if (d < 0) d = -d;
    if (tol == 0) begin
      assert (obs === expv) else begin
        errors++;
        $error("FAIL %s sel=%0d got %0d expected %0d", tag, sel, obs, expv);
      end
    end else begin
      assert (!$isunknown(obs) && d <= tol) else begin
        errors++;
        $error("FAIL %s sel=%0d got %0d expected %0d (+/-%0d)", tag, sel, obs, expv, tol);
      end
    end
  endtask

  task automatic reset_model();
    exp_re_q.delete();
    exp_im_q.delete();
    tol_q.delete();
    vhist.delete();
    last_v   = 1'b0;
    last_re  = '0;
    last_im  = '0;
    last_tol = 0;
  endtask

  // ---------------- driver ----------------
  // Called at posedge+1: drive, take one edge, check at posedge+1.
  task automatic tick(input bit e, input bit v, input int k, input bit inv,
                      input bit exact, input int xre, input int xim);
    int mre;
    int mim;
    int tol;
    bit exp_v;
    logic signed [31:0] er;
    logic signed [31:0] ei;
    en       = e;
    in_valid = v;
    addr_bus = 10'(k);
    inverse  = inv;
    if (e && v) begin
      if (exact) begin
        mre = xre;
        mim = xim;
        tol = 0;
      end else begin
        model(k % (1 << p_log[sel]), p_log[sel], p_w[sel], p_z[sel], inv, mre, mim);
        tol = 1;
      end
      exp_re_q.push_back(mre);
      exp_im_q.push_back(mim);
      tol_q.push_back(tol);
    end
    @(posedge clock);
    if (e) begin
      vhist.push_back(v);
      if (vhist.size() > 3) void'(vhist.pop_front());
      exp_v = (vhist.size() == 3) ? vhist[0] : 1'b0;
    end else begin
      exp_v = last_v;
    end
    #1;
    chk("tw_valid", {31'b0, obs_v}, {31'b0, exp_v}, 0);
    if (e && exp_v && exp_re_q.size() > 0) begin
      er  = exp_re_q.pop_front();
      ei  = exp_im_q.pop_front();
      tol = tol_q.pop_front();
      chk("tw_re", obs_re, er, tol);
      chk("tw_im", obs_im, ei, tol);
      last_re  = er;
      last_im  = ei;
      last_tol = tol;
    end else begin
      chk("hold_re", obs_re, last_re, last_tol);
      chk("hold_im", obs_im, last_im, last_tol);
    end
    last_v = exp_v;
  endtask

  task automatic bubbles(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    en = 1'b0;
    in_valid = 1'b0;
    reset_model();
    @(posedge clock);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  // Reset asserted between edges; outputs must clear without a clock edge.
  task automatic async_reset_check();
    #3;
    reset_n = 1'b0;
    #1;
    chk("rst_valid", {31'b0, obs_v}, 32'sd0, 0);
    chk("rst_re", obs_re, 32'sd0, 0);
    chk("rst_im", obs_im, 32'sd0, 0);
    reset_model();
    @(posedge clock);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic sweep(input int s);
    sel = s;
    pulse_reset();
    for (int k = 0; k < (1 << p_log[sel]); k++) begin
      while ($urandom_range(0, 3) == 0) tick(1'b1, 1'b0, 0, 1'b0, 1'b0, 0, 0);
      tick(1'b1, 1'b1, k, 1'($urandom_range(0, 1)), 1'b0, 0, 0);
    end
    bubbles(4);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    sel      = 0;
    reset_n  = 1'b0;
    en       = 1'b0;
    in_valid = 1'b0;
    inverse  = 1'b0;
    addr_bus = '0;
    reset_model();
    repeat (3) @(posedge clock);
    #1;
    chk("reset_valid", {31'b0, obs_v}, 32'sd0, 0);
    chk("reset_re", obs_re, 32'sd0, 0);
    chk("reset_im", obs_im, 32'sd0, 0);
    reset_n = 1'b1;

    // Back-to-back requests, exact expected codes.
    tick(1, 1, 1,  0, 1, 16'sh7FD9, 16'shF9B8);
    tick(1, 1, 16, 0, 1, 16'sh5A82, 16'shA57E);
    tick(1, 1, 32, 0, 1, 16'sh0000, 16'sh8000);
    tick(1, 1, 66, 0, 1, 16'sh809E, 16'sh0C8C);
    bubbles(4);

    // Zero marker, +1.0 imaginary, conjugate mode with MIN saturation.
    tick(1, 1, 0,  0, 1, 16'sh0000, 16'sh0000);
    tick(1, 1, 96, 0, 1, 16'sh0000, 16'sh7FFF);
    tick(1, 1, 1,  1, 1, 16'sh7FD9, 16'sh0648);
    tick(1, 1, 32, 1, 1, 16'sh0000, 16'sh7FFF);
    bubbles(4);

    // Stall: en=0 for 4 cycles after the first issue; request offered
    // during the stall must not be accepted.
    tick(1, 1, 1, 0, 1, 16'sh7FD9, 16'shF9B8);
    for (int i = 0; i < 4; i++) tick(0, 1, 2, 0, 1, 0, 0);
    tick(1, 1, 2, 0, 1, 16'sh7F62, 16'shF374);
    tick(1, 1, 3, 0, 1, 16'sh7E9D, 16'shED38);
    bubbles(2);
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 0, 0, 0, 0);
    bubbles(3);

    // Randomized traffic with stalls, bubbles and conjugate requests.
    for (int i = 0; i < 80; i++) begin
      tick(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 127)), 1'($urandom_range(0, 1)), 1'b0, 0, 0);
    end
    bubbles(4);

    // Reset with three requests in flight.
    tick(1, 1, 5, 0, 0, 0, 0);
    tick(1, 1, 6, 0, 0, 0, 0);
    tick(1, 1, 7, 1, 0, 0, 0);
    async_reset_check();
    bubbles(4);

    // ZERO_AT_0 = 0: k=0 returns +1.0.
    sel = 1;
    pulse_reset();
    tick(1, 1, 0,  0, 1, 16'sh7FFF, 16'sh0000);
    tick(1, 1, 64, 0, 1, 16'sh8000, 16'sh0000);
    tick(1, 1, 0,  1, 1, 16'sh7FFF, 16'sh0000);
    bubbles(4);

    // Full sweeps with random bubble patterns.
    sweep(2);
    sweep(0);
    sweep(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/twiddle_gen.md
Name: twiddle_gen

Overview:
- Parametrised twiddle-factor generator for N-point radix-2^2 SDF FFT stages; drives the complex multiplier between butterfly stages.
- Replaces full-length N-entry tables with one shared quarter-wave cosine table, N/4+1 entries, built at elaboration.
- Octant/quadrant folding and sign/swap logic reconstruct W_N^k = exp(-j2πk/N).
- Three-stage pipeline with valid tracking, a global stall, and a per-request inverse (conjugate) mode for IFFT.

Parameters:
- LOG_N, 7, log2 of FFT length N; legal range 3..12.
- TW_WIDTH, 16, signed two's-complement width of each twiddle component (Q1.(TW_WIDTH-1)).
- ZERO_AT_0, 1, when 1, k=0 outputs re=0 and im=0 (multiplier bypass marker); when 0, k=0 outputs re=MAX and im=0.

Ports:
- clock  in  1  master clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- en  in  1  pipeline advance enable; 0 stalls every stage.
- in_valid  in  1  request qualifier, sampled when en=1.
- addr  in  LOG_N  twiddle index k, 0..N-1.
- inverse  in  1  1 = return conj(W_N^k); sampled with addr.
- tw_valid  out  1  output qualifier, one cycle per accepted request.
- tw_re  out  TW_WIDTH  real part of the twiddle.
- tw_im  out  TW_WIDTH  imaginary part of the twiddle.

Behaviour:
- Reset (async assert, sync deassert by design integration):
  - All pipeline valids, tw_valid, tw_re and tw_im go to 0.
  - Reset mid-stream discards every in-flight request.
- Constants:
  - MAX = 2^(TW_WIDTH-1)-1, MIN = -2^(TW_WIDTH-1).
  - Q = N/4.
- Table C[i], i=0..Q:
  - C[i] = round(cos(2πi/N) * 2^(TW_WIDTH-1)), clipped to MAX, so C[0]=MAX.
  - Computed by a constant function; no external ROM files.
- Stage 1, registered when en=1:
  - Captures quadrant q=addr[LOG_N-1:LOG_N-2] and r=addr[LOG_N-3:0].
  - Captures ia=r, ib=Q-r (width LOG_N-1 bits, since ib can equal Q).
  - Captures the zero flag (addr==0 and ZERO_AT_0), inverse, and in_valid.
- Stage 2: registers A=C[ia] and B=C[ib], two parallel table reads, plus the sideband bits.
- Stage 3: registers the outputs from quadrant q:
  - q=0: re=A, im=-B
  - q=1: re=-B, im=-A
  - q=2: re=-A, im=B
  - q=3: re=B, im=A
- Negation rule: -MAX yields MIN, so -1.0 is exact (for example k=N/4 gives im=MIN). -MIN saturates to MAX. No other overflow is possible.
- inverse=1 negates im after folding, using the same negation rule.
- Zero flag set: forces re=im=0, overriding the table.
- Latency: 3 enabled clocks from an accepted request to tw_valid=1.
- Throughput: 1 request per enabled clock.
- en=0: all stage registers, tw_valid and outputs hold their values. A request presented while en=0 is not accepted.
- tw_valid=0 cycles: tw_re/tw_im hold the last valid result. Data registers load only when the stage-2 valid is 1.
- in_valid=0 with en=1: a bubble propagates and tw_valid=0 three cycles later.
- addr wraps naturally modulo N; every k in 0..N-1 is legal, with no X entries.

Decomposition:
- Package twiddle_pkg holds:
  - function tw_cos_entry(i, LOG_N, TW_WIDTH)
  - function sat_neg(value, TW_WIDTH)
  - typedef tw_quad_e {Q0,Q1,Q2,Q3}
- Sub-module twiddle_qrom: parametrised dual-read quarter-wave table (LOG_N, TW_WIDTH), combinational reads, instantiated once. Stage registers live in twiddle_gen.

Test Plan:
1. LOG_N=7, W=16, back-to-back requests k=1,16,32,66 with en=1, inverse=0 -> starting 3 cycles later, one per cycle: (7FD9,F9B8), (5A82,A57E), (0000,8000), (809E,0C8C).
2. k=0 with ZERO_AT_0=1 -> (0000,0000). Same request with ZERO_AT_0=0 -> (7FFF,0000). k=96 -> (0000,7FFF).
3. inverse=1: k=1 -> (7FD9,0648); k=32 -> (0000,7FFF), confirming the MIN negation saturates.
4. Stall: issue k=1,2,3, hold en=0 for 4 cycles after the first issue, then release -> tw_valid and outputs frozen during the stall; results (7FD9,F9B8), (7F62,F374), (7E9D,ED38) arrive in order with no loss or duplication.
5. Assert reset_n=0 asynchronously mid-stream with 3 requests in flight -> tw_valid, tw_re and tw_im read 0 immediately; no stale tw_valid after release.
6. Sweep all k for LOG_N=3,7,10 at TW_WIDTH=12,16,18 -> every output within 1 LSB of the cos/-sin model (exact MIN at -1.0); bubble pattern of in_valid reproduced on tw_valid.
